// File: rtl/roi_pkg.sv
// Shared types and default constants for the ROI bounding-box block.
package roi_pkg;

    localparam int ROI_PIX_W   = 8;
    localparam int ROI_IMG_W   = 640;
    localparam int ROI_IMG_H   = 480;
    localparam int ROI_MIN_RUN = 2;
    localparam int ROI_MARGIN  = 4;

    // Run counter is wide enough for the largest allowed MIN_RUN (15).
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } roi_state_e;

    function automatic int roi_clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/roi_run_filter.sv
// Horizontal run-length filter: flags pixels that belong to a foreground run
// of at least MIN_RUN pixels and reports the column where that run began.
module roi_run_filter
    import roi_pkg::*;
#(
    parameter int IMG_W   = ROI_IMG_W,
    parameter int MIN_RUN = ROI_MIN_RUN,
    localparam int CW     = $clog2(IMG_W)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          pix_acc,
    input  logic          restart,
    input  logic          pix_fg,
    input  logic [CW-1:0] col,
    input  logic          row_end,
    output logic          ink,
    output logic [CW-1:0] run_start
);

    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(MIN_RUN);

    logic [RUN_W-1:0] run_q, run_d, run_prev, run_cur;
    logic [CW-1:0]    start_q, start_d, start_cur;

    always_comb begin
        // A restarting frame sees an empty run regardless of leftover history.
        run_prev  = restart ? '0 : run_q;
        run_cur   = '0;
        if (pix_fg) begin
            run_cur = (run_prev == RUN_MAX) ? RUN_MAX : run_prev + 1'b1;
        end
        start_cur = (run_prev == '0) ? col : start_q;
        ink       = pix_acc && pix_fg && (run_cur >= RUN_QUAL);
        run_start = start_cur;

        run_d   = run_q;
        start_d = start_q;
        if (pix_acc) begin
            run_d   = row_end ? '0 : run_cur;
            start_d = start_cur;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            run_q   <= '0;
            start_q <= '0;
        end else begin
            run_q   <= run_d;
            start_q <= start_d;
        end
    end

endmodule

// File: rtl/roi_bbox.sv
// Bounding box of dark ink in a raster-scanned grey frame.
// Optional macro ROI_MARGIN_EN pads a found box by MARGIN, clamped to the frame.
module roi_bbox
    import roi_pkg::*;
#(
    parameter int PIX_W   = ROI_PIX_W,
    parameter int IMG_W   = ROI_IMG_W,
    parameter int IMG_H   = ROI_IMG_H,
    parameter int MIN_RUN = ROI_MIN_RUN,
    parameter int MARGIN  = ROI_MARGIN,
    localparam int CW     = $clog2(IMG_W),
    localparam int RW     = $clog2(IMG_H)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [PIX_W-1:0] iPixel,
    input  logic             iPix_val,
    input  logic             iSOF,
    input  logic [PIX_W-1:0] iThresh,
    output logic [RW-1:0]    oTop,
    output logic [RW-1:0]    oBot,
    output logic [CW-1:0]    oLeft,
    output logic [CW-1:0]    oRight,
    output logic             oFound,
    output logic             oROI_val,
    output logic             oBusy
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    roi_state_e       state_q, state_d;
    logic [PIX_W-1:0] thresh_q, thresh_d;
    logic [CW-1:0]    col_q, col_d, left_q, left_d, right_q, right_d;
    logic [RW-1:0]    row_q, row_d, top_q, top_d, bot_q, bot_d;
    logic             ink_q, ink_d;

    logic [RW-1:0]    out_top_q, out_top_d, out_bot_q, out_bot_d;
    logic [CW-1:0]    out_left_q, out_left_d, out_right_q, out_right_d;
    logic             out_found_q, out_found_d, roi_val_q, roi_val_d;

    logic             restart, pix_acc, pix_fg, row_end, last_pix, base_ink;
    logic             ink_hit;
    logic [CW-1:0]    cur_col, run_start, box_left, box_right;
    logic [RW-1:0]    cur_row, box_top, box_bot;

`ifdef ROI_MARGIN_EN
    function automatic logic [RW-1:0] pad_row(input logic [RW-1:0] v, input logic grow_up);
        return RW'(roi_clamp(grow_up ? int'(v) + MARGIN : int'(v) - MARGIN, 0, IMG_H - 1));
    endfunction

    function automatic logic [CW-1:0] pad_col(input logic [CW-1:0] v, input logic grow_up);
        return CW'(roi_clamp(grow_up ? int'(v) + MARGIN : int'(v) - MARGIN, 0, IMG_W - 1));
    endfunction
`endif

    // Pixel acceptance and coordinates; a restart pixel is always (0,0).
    always_comb begin
        restart  = iPix_val && iSOF && (state_q != ST_DONE);
        pix_acc  = restart || (iPix_val && (state_q == ST_SCAN));
        cur_col  = restart ? '0 : col_q;
        cur_row  = restart ? '0 : row_q;
        pix_fg   = iPixel < (restart ? iThresh : thresh_q);
        row_end  = (cur_col == COL_MAX);
        last_pix = pix_acc && row_end && (cur_row == ROW_MAX);
    end

    roi_run_filter #(
        .IMG_W   (IMG_W),
        .MIN_RUN (MIN_RUN)
    ) u_run_filter (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .pix_acc   (pix_acc),
        .restart   (restart),
        .pix_fg    (pix_fg),
        .col       (cur_col),
        .row_end   (row_end),
        .ink       (ink_hit),
        .run_start (run_start)
    );

    always_comb begin
        thresh_d = restart ? iThresh : thresh_q;

        col_d = col_q;
        row_d = row_q;
        if (pix_acc) begin
            col_d = row_end ? '0 : cur_col + 1'b1;
            row_d = row_end ? cur_row + 1'b1 : cur_row;
            if (last_pix) row_d = '0;
        end

        // Box registers are only meaningful once ink_q is set, so a restart
        // just drops the flag and lets the first hit overwrite them.
        base_ink = restart ? 1'b0 : ink_q;
        ink_d    = base_ink;
        left_d   = left_q;
        right_d  = right_q;
        top_d    = top_q;
        bot_d    = bot_q;
        if (ink_hit) begin
            ink_d = 1'b1;
            bot_d = cur_row;
            if (!base_ink) begin
                left_d  = run_start;
                right_d = cur_col;
                top_d   = cur_row;
            end else begin
                if (run_start < left_q) left_d  = run_start;
                if (cur_col > right_q)  right_d = cur_col;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (last_pix) state_d = ST_DONE;
                     else if (restart) state_d = ST_SCAN;
            ST_SCAN: if (last_pix) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        box_top   = '0;
        box_bot   = ROW_MAX;
        box_left  = '0;
        box_right = COL_MAX;
        if (ink_d) begin
`ifdef ROI_MARGIN_EN
            box_top   = pad_row(top_d, 1'b0);
            box_bot   = pad_row(bot_d, 1'b1);
            box_left  = pad_col(left_d, 1'b0);
            box_right = pad_col(right_d, 1'b1);
`else
            box_top   = top_d;
            box_bot   = bot_d;
            box_left  = left_d;
            box_right = right_d;
`endif
        end

        // Results land on the last-pixel edge so they are valid during DONE.
        roi_val_d   = last_pix;
        out_top_d   = out_top_q;
        out_bot_d   = out_bot_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_found_d = out_found_q;
        if (last_pix) begin
            out_top_d   = box_top;
            out_bot_d   = box_bot;
            out_left_d  = box_left;
            out_right_d = box_right;
            out_found_d = ink_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= ST_IDLE;
            thresh_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ink_q       <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            top_q       <= '0;
            bot_q       <= '0;
            out_top_q   <= '0;
            out_bot_q   <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_found_q <= 1'b0;
            roi_val_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ink_q       <= ink_d;
            left_q      <= left_d;
            right_q     <= right_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            out_top_q   <= out_top_d;
            out_bot_q   <= out_bot_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_found_q <= out_found_d;
            roi_val_q   <= roi_val_d;
        end
    end

    assign oTop     = out_top_q;
    assign oBot     = out_bot_q;
    assign oLeft    = out_left_q;
    assign oRight   = out_right_q;
    assign oFound   = out_found_q;
    assign oROI_val = roi_val_q;
    assign oBusy    = (state_q == ST_SCAN);

endmodule

// File: tb/tb_roi_bbox.sv
// Self-checking bench for roi_bbox on a 16x8 frame with MIN_RUN=2, MARGIN=4.
module tb_roi_bbox;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int MR = 2;
    localparam int MG = 4;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic [7:0] iPixel = '0;
    logic [7:0] iThresh = '0;
    logic       iPix_val = 1'b0;
    logic       iSOF = 1'b0;
    logic [2:0] oTop, oBot;
    logic [3:0] oLeft, oRight;
    logic       oFound, oROI_val, oBusy;

    roi_bbox #(
        .PIX_W   (8),
        .IMG_W   (W),
        .IMG_H   (H),
        .MIN_RUN (MR),
        .MARGIN  (MG)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iPixel   (iPixel),
        .iPix_val (iPix_val),
        .iSOF     (iSOF),
        .iThresh  (iThresh),
        .oTop     (oTop),
        .oBot     (oBot),
        .oLeft    (oLeft),
        .oRight   (oRight),
        .oFound   (oFound),
        .oROI_val (oROI_val),
        .oBusy    (oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int cyc;
        int found;
        int top;
        int bot;
        int left;
        int right;
    } exp_t;

    exp_t q[$];
    exp_t held;
    exp_t ce;
    exp_t got;
    int   fr[H][W];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   strobes = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pack(input int f, input int t, input int b, input int l, input int r);
        return (f << 16) | (t << 12) | (b << 8) | (l << 4) | r;
    endfunction

    // Reference: find every horizontal dark run, keep those of length >= MR.
    function automatic exp_t model(input int thr);
        exp_t e;
        int l = W, r = -1, t = H, b = -1;
        int c, s;
        for (int y = 0; y < H; y++) begin
            c = 0;
            while (c < W) begin
                if (fr[y][c] < thr) begin
                    s = c;
                    while (c < W && fr[y][c] < thr) c++;
                    if (c - s >= MR) begin
                        if (s < l) l = s;
                        if (c - 1 > r) r = c - 1;
                        if (y < t) t = y;
                        if (y > b) b = y;
                    end
                end else begin
                    c++;
                end
            end
        end
        e.cyc = 0;
        if (r < 0) begin
            e.found = 0; e.top = 0; e.bot = H - 1; e.left = 0; e.right = W - 1;
        end else begin
            e.found = 1; e.top = t; e.bot = b; e.left = l; e.right = r;
`ifdef ROI_MARGIN_EN
            e.top   = (t - MG < 0) ? 0 : t - MG;
            e.bot   = (b + MG > H - 1) ? H - 1 : b + MG;
            e.left  = (l - MG < 0) ? 0 : l - MG;
            e.right = (r + MG > W - 1) ? W - 1 : r + MG;
`endif
        end
        return e;
    endfunction

    always @(negedge iCLK) begin
        if (!iRST) begin
            chk("reset_outputs", int'({oROI_val, oBusy, oFound, oTop, oBot, oLeft, oRight}), 0);
            held = '{0, 0, 0, 0, 0, 0};
        end else begin
            if (oROI_val) begin
                strobes++;
                got = '{cyc, int'(oFound), int'(oTop), int'(oBot), int'(oLeft), int'(oRight)};
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ce = q.pop_front();
                chk("strobe", int'(oROI_val), 1);
                chk("strobe_busy", int'(oBusy), 0);
                chk("found", int'(oFound), ce.found);
                chk("top", int'(oTop), ce.top);
                chk("bot", int'(oBot), ce.bot);
                chk("left", int'(oLeft), ce.left);
                chk("right", int'(oRight), ce.right);
                held = ce;
            end else begin
                chk("no_strobe", int'(oROI_val), 0);
                chk("hold", pack(int'(oFound), int'(oTop), int'(oBot), int'(oLeft), int'(oRight)),
                    pack(held.found, held.top, held.bot, held.left, held.right));
            end
        end
    end

    task automatic fill(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = v;
    endtask

    task automatic rect(input int y0, input int y1, input int x0, input int x1, input int v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                fr[y][x] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK); #1;
            iPix_val = 1'b0;
            iSOF     = 1'b0;
        end
    endtask

    // Stream raster indices first..last; threshold only valid on the SOF pixel.
    task automatic send_range(input int first, input int last, input bit sof,
                              input int thr, input bit expect_res, input bit gaps);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge iCLK); #1;
                iPix_val = 1'b0;
                iSOF     = 1'($urandom_range(0, 1));
                iPixel   = 8'($urandom);
            end
            @(posedge iCLK); #1;
            iPix_val = 1'b1;
            iSOF     = sof && (i == first);
            iPixel   = 8'(fr[i / W][i % W]);
            iThresh  = (sof && i == first) ? 8'(thr) : 8'($urandom_range(0, 255));
            if (expect_res && i == H * W - 1) begin
                e     = model(thr);
                e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic lit(input string n, input exp_t m, input int f, input int t,
                       input int b, input int l, input int r);
        chk({n, "_model"}, pack(m.found, m.top, m.bot, m.left, m.right), pack(f, t, b, l, r));
        chk({n, "_dut"}, pack(got.found, got.top, got.bot, got.left, got.right), pack(f, t, b, l, r));
    endtask

    task automatic req038_frame();
        fill(255);
        rect(2, 4, 5, 9, 0);
    endtask

    int s0;

    initial begin
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;
        idle(2);

        // All-paper frame.
        fill(255);
        send_range(0, H * W - 1, 1, 128, 1, 1);
        idle(4);
        lit("req037", model(128), 0, 0, 7, 0, 15);

        // Solid block; busy must be high mid-frame.
        req038_frame();
        send_range(0, 10, 1, 128, 0, 0);
        @(negedge iCLK);
        chk("busy_scan", int'(oBusy), 1);
        send_range(11, H * W - 1, 0, 128, 1, 1);
        idle(4);
`ifdef ROI_MARGIN_EN
        lit("req040", model(128), 1, 0, 7, 1, 13);
`else
        lit("req038", model(128), 1, 2, 4, 5, 9);
`endif

        // A lone dark pixel is below MIN_RUN.
        fill(255);
        fr[3][3] = 0;
        send_range(0, H * W - 1, 1, 128, 1, 1);
        idle(4);
        lit("req039", model(128), 0, 0, 7, 0, 15);

        // Runs must not join across the row wrap; right edge run of two.
        fill(255);
        fr[1][15] = 0;
        fr[2][0]  = 0;
        fr[6][14] = 0;
        fr[6][15] = 0;
        send_range(0, H * W - 1, 1, 128, 1, 1);
        idle(4);

        // Strict less-than threshold boundary plus a saturating full-width run.
        fill(200);
        rect(1, 5, 2, 12, 100);
        rect(7, 7, 0, 15, 40);
        send_range(0, H * W - 1, 1, 100, 1, 1);
        idle(3);
        send_range(0, H * W - 1, 1, 101, 1, 1);
        idle(4);

        // Back-to-back: the SOF presented during DONE must be ignored.
        req038_frame();
        s0 = strobes;
        send_range(0, H * W - 1, 1, 128, 1, 0);
        send_range(0, H * W - 1, 1, 128, 0, 0);
        idle(4);
        chk("done_ignore_strobes", strobes - s0, 1);

        // Abort mid-frame with a new SOF at row 3.
        fill(0);
        s0 = strobes;
        send_range(0, 3 * W + 5, 1, 128, 0, 1);
        req038_frame();
        send_range(0, H * W - 1, 1, 128, 1, 1);
        idle(4);
        chk("abort_strobes", strobes - s0, 1);
`ifdef ROI_MARGIN_EN
        lit("req041", model(128), 1, 0, 7, 1, 13);
`else
        lit("req041", model(128), 1, 2, 4, 5, 9);
`endif

        // Reset at row 5, remaining pixels without SOF, then a clean frame.
        fill(0);
        s0 = strobes;
        send_range(0, 5 * W + 6, 1, 128, 0, 1);
        @(posedge iCLK); #1;
        iRST     = 1'b0;
        iPix_val = 1'b0;
        iSOF     = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b1;
        send_range(5 * W + 7, H * W - 1, 0, 128, 0, 1);
        idle(4);
        chk("reset_no_strobe", strobes - s0, 0);
        chk("reset_idle_busy", int'(oBusy), 0);
        req038_frame();
        send_range(0, H * W - 1, 1, 128, 1, 1);
        idle(4);
`ifdef ROI_MARGIN_EN
        lit("req042", model(128), 1, 0, 7, 1, 13);
`else
        lit("req042", model(128), 1, 2, 4, 5, 9);
`endif

        chk("pending_results", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
